dm_cache_ctrl: RTL and testbench
================================

// Module: dm_cache_ctrl
// PURPOSE
//  Direct-mapped, write-through, no-write-allocate cache controller between the CPU request port and the
//  1024x32 word-addressed main RAM, which has a one-cycle read and is clocked on negedge clk.
//  Holds 2**INDEX_BITS one-word lines in flops. Serves read hits locally; fills the line on a read miss.
//  Forwards every write to RAM. Keeps saturating hit/miss counters.
// PARAMETERS
//  ADDR_BITS   10  word address width; matches the RAM depth
//  DATA_BITS   32  word width
//  INDEX_BITS  4   line index width; TAG_BITS = ADDR_BITS-INDEX_BITS
//  MEM_RD_LAT  1   clk edges from mem_r_en assertion to mem_rdata valid (>=1)
//  CNT_BITS    16  width of hit_cnt/miss_cnt
// PORTS
//  clk         in   1          system clock; all state updates on posedge
//  rst_n       in   1          synchronous active-low reset
//  cpu_req     in   1          request strobe; accepted only when cpu_busy=0
//  cpu_we      in   1          1=write, 0=read; sampled with cpu_req
//  cpu_addr    in   ADDR_BITS  word address {tag,index}
//  cpu_wdata   in   DATA_BITS  write data
//  cpu_busy    out  1          high in every state except IDLE
//  cpu_ready   out  1          one-cycle completion pulse
//  cpu_rdata   out  DATA_BITS  read data; valid while cpu_ready=1 on a read; otherwise holds its last value
//  cpu_hit     out  1          hit flag for the completing access; qualified by cpu_ready
//  flush       in   1          invalidate all lines; honoured only in IDLE
//  mem_r_en    out  1          RAM read enable
//  mem_w_en    out  1          RAM write enable
//  mem_addr    out  ADDR_BITS  RAM address (latched cpu_addr)
//  mem_wdata   out  DATA_BITS  RAM write data
//  mem_rdata   in   DATA_BITS  RAM read data
//  hit_cnt     out  CNT_BITS   saturating count of hits
//  miss_cnt    out  CNT_BITS   saturating count of misses
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//  - state=IDLE; all valid bits=0.
//  - cpu_ready, cpu_hit, mem_r_en, mem_w_en, hit_cnt and miss_cnt = 0.
//  - cpu_rdata, mem_addr and mem_wdata = 0. Tag/data arrays are not cleared.
//  Mid-operation reset aborts the access and never pulses cpu_ready. A RAM write already presented may complete.
//  FSM (all outputs registered or decoded from state):
//  - IDLE: cpu_busy=0. If flush=1, clear all valid bits and stay in IDLE.
//    Else if cpu_req=1, latch we/addr/wdata and go to LOOKUP. flush has priority over cpu_req;
//    the request is not accepted and must be held by the CPU.
//  - LOOKUP: hit = valid[idx] && tag[idx]==addr_tag.
//    Read hit  -> DONE; cpu_rdata=data[idx]; cpu_hit=1; hit_cnt++.
//    Read miss -> MEM_RD; mem_r_en=1; wait counter=0; miss_cnt++.
//    Write     -> MEM_WR; mem_w_en=1, mem_wdata=wdata. On a write hit: data[idx]=wdata and hit_cnt++.
//                 On a write miss: no line change, miss_cnt++.
//  - MEM_RD: mem_r_en stays 1 and the counter increments. On the edge where counter==MEM_RD_LAT-1:
//    capture mem_rdata into data[idx] and cpu_rdata; set tag[idx] and valid[idx]; cpu_hit=0;
//    mem_r_en=0; go to DONE.
//  - MEM_WR: exactly one cycle; mem_w_en=0 on exit; go to DONE. cpu_hit = the LOOKUP hit result.
//  - DONE: cpu_ready=1 for exactly one cycle, then IDLE.
//  Latency, with the request accepted at edge N and cpu_ready high in the cycle after edge X:
//  - read hit X=N+1; read miss X=N+1+MEM_RD_LAT; write X=N+2.
//  - A new request can be accepted in the cycle after cpu_ready, so the minimum issue interval is 3 cycles.
//  mem_r_en and mem_w_en are never both 1. mem_addr is stable for the whole RAM access.
//  Counters saturate at all-ones; no wrap. Inputs are ignored while cpu_busy=1.
//  index = cpu_addr[INDEX_BITS-1:0]; tag = cpu_addr[ADDR_BITS-1:INDEX_BITS].
// TESTING
//  1 Cold read 0x025 with RAM[0x025]=0xDEADBEEF -> miss.
//    mem_r_en for 1 cycle; ready at N+2; rdata=0xDEADBEEF, hit=0; miss_cnt=1.
//  2 Re-read 0x025 -> ready at N+1, hit=1, no mem_r_en; hit_cnt=1.
//  3 Read 0x035 (same index 5, tag 3) after test 2 -> miss; line replaced.
//    Then read 0x025 -> miss again; miss_cnt=3.
//  4 Write 0x035=0x12345678 while line valid -> mem_w_en one cycle; ready at N+2, hit=1.
//    Re-read 0x035 -> hit returns 0x12345678; RAM[0x035]=0x12345678.
//    Write miss 0x100=0xA5A5A5A5 -> RAM updated; line 0 stays invalid.
//  5 flush=1 together with cpu_req=1 in IDLE -> request not accepted, valid cleared.
//    Next read of 0x035 -> miss.
//  6 Assert rst_n=0 during MEM_RD -> no cpu_ready; next cycle mem_r_en=0, counters=0.
//    All lines invalid: a read of 0x025 misses.

Source files
------------

// File: rtl/dm_cache_if.sv
// CPU-side and RAM-side signal bundle of the direct-mapped cache controller.
// The controller takes the slave modport; the requester/RAM side takes master.
interface dm_cache_if #(
  parameter int ADDR_BITS = 10,
  parameter int DATA_BITS = 32,
  parameter int CNT_BITS  = 16
);
  // Handshake: cpu_req is taken on a rising edge only while cpu_busy is low and
  // flush is low; the requester holds cpu_req/cpu_we/cpu_addr/cpu_wdata until then.
  // Completion is the one-cycle cpu_ready pulse; cpu_rdata/cpu_hit qualify with it.
  logic                 cpu_req;
  logic                 cpu_we;
  logic [ADDR_BITS-1:0] cpu_addr;
  logic [DATA_BITS-1:0] cpu_wdata;
  logic                 cpu_busy;
  logic                 cpu_ready;
  logic [DATA_BITS-1:0] cpu_rdata;
  logic                 cpu_hit;
  logic                 flush;
  logic                 mem_r_en;
  logic                 mem_w_en;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;
  logic [CNT_BITS-1:0]  hit_cnt;
  logic [CNT_BITS-1:0]  miss_cnt;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
    output cpu_busy, cpu_ready, cpu_rdata, cpu_hit,
    output mem_r_en, mem_w_en, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, flush, mem_rdata,
    input  cpu_busy, cpu_ready, cpu_rdata, cpu_hit,
    input  mem_r_en, mem_w_en, mem_addr, mem_wdata, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller with one-word
// lines held in flops, read-miss fill from RAM and saturating hit/miss counters.
module dm_cache_ctrl #(
  parameter int ADDR_BITS  = 10,
  parameter int DATA_BITS  = 32,
  parameter int INDEX_BITS = 4,
  parameter int MEM_RD_LAT = 1,
  parameter int CNT_BITS   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  dm_cache_if.slave   bus,
  output logic [2:0]  dbg_state_o
);
  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS;
  localparam int NLINES   = 2 ** INDEX_BITS;
  localparam int LAT_W    = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic                 we_q, we_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] rdata_q, rdata_d;
  logic                 hit_q, hit_d;
  logic                 ready_q, ready_d;
  logic                 r_en_q, r_en_d;
  logic                 w_en_q, w_en_d;
  logic [DATA_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                 lk_hit_q, lk_hit_d;
  logic [CNT_BITS-1:0]  hit_cnt_q, hit_cnt_d;
  logic [CNT_BITS-1:0]  miss_cnt_q, miss_cnt_d;

  logic [NLINES-1:0]    valid_q;
  logic [TAG_BITS-1:0]  tag_q  [NLINES];
  logic [DATA_BITS-1:0] data_q [NLINES];

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  lookup_hit;
  logic                  flush_all;
  logic                  line_we;
  logic                  line_fill;
  logic [DATA_BITS-1:0]  line_wdata;

  // The latched request address doubles as the RAM address, so it stays put for the whole access.
  assign idx        = addr_q[INDEX_BITS-1:0];
  assign tag        = addr_q[ADDR_BITS-1:INDEX_BITS];
  assign lookup_hit = valid_q[idx] && (tag_q[idx] == tag);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    hit_d       = hit_q;
    ready_d     = 1'b0;
    r_en_d      = r_en_q;
    w_en_d      = w_en_q;
    mem_wdata_d = mem_wdata_q;
    lk_hit_d    = lk_hit_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    flush_all   = 1'b0;
    line_we     = 1'b0;
    line_fill   = 1'b0;
    line_wdata  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.flush) begin
          flush_all = 1'b1;
        end else if (bus.cpu_req) begin
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        lk_hit_d = lookup_hit;
        if (lookup_hit) begin
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_BITS'(1);
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_BITS'(1);
        end
        if (we_q) begin
          w_en_d      = 1'b1;
          mem_wdata_d = wdata_q;
          line_we     = lookup_hit;
          line_wdata  = wdata_q;
          state_d     = S_MEM_WR;
        end else if (lookup_hit) begin
          rdata_d = data_q[idx];
          hit_d   = 1'b1;
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          r_en_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_MEM_RD;
        end
      end
      S_MEM_RD: begin
        if (cnt_q == LAT_W'(MEM_RD_LAT - 1)) begin
          line_we    = 1'b1;
          line_fill  = 1'b1;
          line_wdata = bus.mem_rdata;
          rdata_d    = bus.mem_rdata;
          hit_d      = 1'b0;
          r_en_d     = 1'b0;
          ready_d    = 1'b1;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + LAT_W'(1);
        end
      end
      S_MEM_WR: begin
        w_en_d  = 1'b0;
        hit_d   = lk_hit_q;
        ready_d = 1'b1;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      hit_q       <= 1'b0;
      ready_q     <= 1'b0;
      r_en_q      <= 1'b0;
      w_en_q      <= 1'b0;
      mem_wdata_q <= '0;
      lk_hit_q    <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      hit_q       <= hit_d;
      ready_q     <= ready_d;
      r_en_q      <= r_en_d;
      w_en_q      <= w_en_d;
      mem_wdata_q <= mem_wdata_d;
      lk_hit_q    <= lk_hit_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      if (flush_all)      valid_q      <= '0;
      else if (line_fill) valid_q[idx] <= 1'b1;
    end
  end

  // Tag/data storage is never reset; the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (rst_n && line_we)   data_q[idx] <= line_wdata;
    if (rst_n && line_fill) tag_q[idx]  <= tag;
  end

  assign bus.cpu_busy  = (state_q != S_IDLE);
  assign bus.cpu_ready = ready_q;
  assign bus.cpu_rdata = rdata_q;
  assign bus.cpu_hit   = hit_q;
  assign bus.mem_r_en  = r_en_q;
  assign bus.mem_w_en  = w_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.miss_cnt  = miss_cnt_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed vector table, flush/reset
// sequences and a random phase checked against a small cache/RAM model.
module tb_dm_cache_ctrl;
  localparam int AB  = 10;
  localparam int DB  = 32;
  localparam int IB  = 4;
  localparam int LAT = 1;
  localparam int CB  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dm_cache_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .CNT_BITS(CB)) bus ();
  logic [2:0] dbg_state;

  dm_cache_ctrl #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .INDEX_BITS(IB), .MEM_RD_LAT(LAT), .CNT_BITS(CB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---------------- RAM model (negedge clocked) ----------------
  logic [DB-1:0] ram [1024];
  always @(negedge clk) begin
    if (bus.mem_w_en) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_r_en) bus.mem_rdata     <= ram[bus.mem_addr];
  end

  // ---------------- reference model ----------------
  logic [DB-1:0]    ref_mem [1024];
  logic [15:0]      m_valid;
  logic [AB-IB-1:0] m_tag [16];
  int               exp_hits;
  int               exp_misses;

  function automatic void model_access(input logic we, input logic [AB-1:0] a,
                                       input logic [DB-1:0] wd,
                                       output logic hit, output logic [DB-1:0] rd);
    logic [IB-1:0]    i;
    logic [AB-IB-1:0] t;
    i   = a[IB-1:0];
    t   = a[AB-1:IB];
    hit = m_valid[i] && (m_tag[i] == t);
    rd  = '0;
    if (we) begin
      ref_mem[a] = wd;
    end else begin
      rd = ref_mem[a];
      if (!hit) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = t;
      end
    end
  endfunction

  // ---------------- scoreboard ----------------
  int n_vec  = 0;
  int n_fail = 0;
  // {we, lat[3:0], hit, rdata}
  logic [37:0] exp_q [$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_access(input logic we, input logic [AB-1:0] addr, input logic [DB-1:0] wdata,
                           input logic exp_hit, input logic [DB-1:0] exp_rdata,
                           input int exp_lat, input string nm);
    int          lat;
    int          ren;
    int          wen;
    logic        got;
    logic [37:0] e;
    @(negedge clk);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.flush     = 1'b0;
    exp_q.push_back({we, 4'(exp_lat), exp_hit, exp_rdata});
    if (exp_hit) exp_hits++; else exp_misses++;
    @(posedge clk); #1;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = ~addr;
    bus.cpu_wdata = ~wdata;
    check({nm, ":busy"}, bus.cpu_busy, 1);
    lat = 0; ren = 0; wen = 0; got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.mem_r_en) ren++;
      if (bus.mem_w_en) wen++;
      if (bus.mem_r_en || bus.mem_w_en) begin
        check({nm, ":mem_addr"}, bus.mem_addr, addr);
        check({nm, ":r_w_exclusive"}, bus.mem_r_en & bus.mem_w_en, 0);
      end
      if (bus.mem_w_en) check({nm, ":mem_wdata"}, bus.mem_wdata, wdata);
      if (bus.cpu_ready) got = 1'b1;
    end
    if (!got) begin
      check({nm, ":timeout_ready"}, bus.cpu_ready, 1);
      void'(exp_q.pop_front());
    end else if (exp_q.size() == 0) begin
      check({nm, ":scoreboard_empty"}, exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check({nm, ":latency"}, lat, e[36:33]);
      check({nm, ":hit"}, bus.cpu_hit, e[32]);
      if (!e[37]) check({nm, ":rdata"}, bus.cpu_rdata, e[31:0]);
    end
    check({nm, ":r_en_cycles"}, ren, (we || exp_hit) ? 0 : LAT);
    check({nm, ":w_en_cycles"}, wen, we ? 1 : 0);
    @(posedge clk); #1;
    check({nm, ":ready_one_cycle"}, bus.cpu_ready, 0);
    check({nm, ":idle_after"}, bus.cpu_busy, 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          we;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic          exp_hit;
    logic [DB-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic          hit;
    logic [DB-1:0] rd;
    logic [AB-1:0] a;
    logic [DB-1:0] wd;
    logic          we;

    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
    bus.cpu_wdata = '0; bus.flush = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ram[i]     = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
    ram[10'h025]     = 32'hDEADBEEF;
    ref_mem[10'h025] = 32'hDEADBEEF;
    m_valid = '0; exp_hits = 0; exp_misses = 0;

    //            we    addr     wdata          hit   rdata          latency
    tbl[0]  = '{1'b0, 10'h025, 32'h0,         1'b0, 32'hDEADBEEF, 1 + LAT};
    tbl[1]  = '{1'b0, 10'h025, 32'h0,         1'b1, 32'hDEADBEEF, 1};
    tbl[2]  = '{1'b0, 10'h035, 32'h0,         1'b0, 32'hC0DE0035, 1 + LAT};
    tbl[3]  = '{1'b0, 10'h025, 32'h0,         1'b0, 32'hDEADBEEF, 1 + LAT};
    tbl[4]  = '{1'b0, 10'h035, 32'h0,         1'b0, 32'hC0DE0035, 1 + LAT};
    tbl[5]  = '{1'b1, 10'h035, 32'h12345678,  1'b1, 32'h0,        2};
    tbl[6]  = '{1'b0, 10'h035, 32'h0,         1'b1, 32'h12345678, 1};
    tbl[7]  = '{1'b1, 10'h100, 32'hA5A5A5A5,  1'b0, 32'h0,        2};
    tbl[8]  = '{1'b0, 10'h100, 32'h0,         1'b0, 32'hA5A5A5A5, 1 + LAT};
    tbl[9]  = '{1'b0, 10'h100, 32'h0,         1'b1, 32'hA5A5A5A5, 1};
    tbl[10] = '{1'b0, 10'h3FF, 32'h0,         1'b0, 32'hC0DE03FF, 1 + LAT};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy",      bus.cpu_busy,  0);
    check("rst:ready",     bus.cpu_ready, 0);
    check("rst:hit",       bus.cpu_hit,   0);
    check("rst:rdata",     bus.cpu_rdata, 0);
    check("rst:mem_r_en",  bus.mem_r_en,  0);
    check("rst:mem_w_en",  bus.mem_w_en,  0);
    check("rst:mem_addr",  bus.mem_addr,  0);
    check("rst:mem_wdata", bus.mem_wdata, 0);
    check("rst:hit_cnt",   bus.hit_cnt,   0);
    check("rst:miss_cnt",  bus.miss_cnt,  0);
    @(negedge clk); rst_n = 1'b1;

    // directed table
    for (int i = 0; i < 11; i++) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, hit, rd);
      do_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_hit, tbl[i].exp_rdata,
                tbl[i].exp_lat, $sformatf("vec%0d", i));
    end
    check("tbl:hit_cnt",  bus.hit_cnt,  exp_hits);
    check("tbl:miss_cnt", bus.miss_cnt, exp_misses);
    check("tbl:ram_035",  ram[10'h035], 32'h12345678);
    check("tbl:ram_100",  ram[10'h100], 32'hA5A5A5A5);

    // flush together with a request: not accepted, all lines dropped
    @(negedge clk);
    bus.flush = 1'b1; bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h035;
    @(posedge clk); #1;
    check("flush:not_accepted", bus.cpu_busy, 0);
    check("flush:state_idle",   dbg_state,    0);
    bus.flush = 1'b0;
    m_valid = '0;
    model_access(1'b0, 10'h035, '0, hit, rd);
    do_access(1'b0, 10'h035, '0, 1'b0, 32'h12345678, 1 + LAT, "flush:reread");

    // reset while waiting on a RAM read
    @(negedge clk);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h025;
    @(posedge clk); #1;
    bus.cpu_req = 1'b0;
    @(posedge clk); #1;
    check("midrst:in_mem_rd", bus.mem_r_en, 1);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst:ready",    bus.cpu_ready, 0);
    check("midrst:mem_r_en", bus.mem_r_en,  0);
    check("midrst:hit_cnt",  bus.hit_cnt,   0);
    check("midrst:miss_cnt", bus.miss_cnt,  0);
    check("midrst:busy",     bus.cpu_busy,  0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst:no_ready", bus.cpu_ready, 0);
    end
    m_valid = '0; exp_hits = 0; exp_misses = 0;
    model_access(1'b0, 10'h025, '0, hit, rd);
    do_access(1'b0, 10'h025, '0, 1'b0, 32'hDEADBEEF, 1 + LAT, "midrst:reread");
    check("midrst:miss_cnt_after", bus.miss_cnt, 1);

    // random traffic over a small footprint so hits and conflicts are frequent
    for (int i = 0; i < 40; i++) begin
      we = ($urandom_range(0, 3) == 0);
      a  = AB'($urandom_range(0, 63));
      wd = $urandom;
      model_access(we, a, wd, hit, rd);
      do_access(we, a, wd, hit, rd, we ? 2 : (hit ? 1 : 1 + LAT), $sformatf("rnd%0d", i));
    end
    check("rnd:hit_cnt",  bus.hit_cnt,  exp_hits);
    check("rnd:miss_cnt", bus.miss_cnt, exp_misses);
    for (int i = 0; i < 64; i++) check("rnd:ram", ram[i], ref_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no summary expected finish within time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
